// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle add/sub processing CHUNK bits per clock with a registered inter-chunk carry
module chunked_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             ci,
  input  logic             sub,
  output logic [WIDTH-1:0] o,
  output logic             co,
  output logic             ovf,
  output logic             done,
  output logic             busy
);
  localparam int N  = WIDTH / CHUNK;
  localparam int KW = N > 1 ? $clog2(N) : 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d, o_q, o_d;
  logic c_q, c_d, co_q, co_d, ovf_q, ovf_d, done_q, done_d;
  logic [CHUNK:0] sum;
  logic last;
  always_comb begin
    sum = {1'b0, a_q[k_q*CHUNK +: CHUNK]} + {1'b0, b_q[k_q*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, c_q};
    last = k_q == KW'(N - 1);
    state_d = state_q;
    k_d = k_q;
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    s_d = s_q;
    o_d = o_q;
    co_d = co_q;
    ovf_d = ovf_q;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      if (start_valid) begin
        a_d = x;
        b_d = sub ? ~y : y;
        c_d = ci ^ sub;
        k_d = '0;
        state_d = RUN;
      end
    end else begin
      s_d[k_q*CHUNK +: CHUNK] = sum[CHUNK-1:0];
      c_d = sum[CHUNK];
      k_d = k_q + 1'b1;
      if (last) begin
        o_d = s_d;
        co_d = sum[CHUNK];
        ovf_d = sum[CHUNK-1] ^ a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ sum[CHUNK];
        done_d = 1'b1;
        state_d = IDLE;
        k_d = '0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q <= '0;
      a_q <= '0;
      b_q <= '0;
      c_q <= 1'b0;
      s_q <= '0;
      o_q <= '0;
      co_q <= 1'b0;
      ovf_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      s_q <= s_d;
      o_q <= o_d;
      co_q <= co_d;
      ovf_q <= ovf_d;
      done_q <= done_d;
    end
  end
  assign start_ready = state_q == IDLE && !rst;
  assign busy = state_q == RUN;
  assign o = o_q;
  assign co = co_q;
  assign ovf = ovf_q;
  assign done = done_q;
endmodule

// File: tb/tb_chunked_adder.sv
// tb_chunked_adder: directed and randomized checks of chunked_adder across several WIDTH/CHUNK choices
module tb_chunked_adder;
  logic clk = 1'b0, rst = 1'b1, start_valid = 1'b0, ci = 1'b0, sub = 1'b0;
  logic [31:0] x = '0, y = '0;
  logic [15:0] o0, o1, o2;
  logic [31:0] o3;
  logic [3:0] rdy, dn, coa, ova, bsy;
  logic [31:0] oa [4];
  int checks = 0, failures = 0;
  localparam int W [4] = '{16, 16, 16, 32};
  localparam int NN [4] = '{4, 16, 1, 4};
  always #5 clk = ~clk;
  chunked_adder #(.WIDTH(16), .CHUNK(4)) u0 (.clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(rdy[0]),
    .x(x[15:0]), .y(y[15:0]), .ci(ci), .sub(sub), .o(o0), .co(coa[0]), .ovf(ova[0]), .done(dn[0]), .busy(bsy[0]));
  chunked_adder #(.WIDTH(16), .CHUNK(1)) u1 (.clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(rdy[1]),
    .x(x[15:0]), .y(y[15:0]), .ci(ci), .sub(sub), .o(o1), .co(coa[1]), .ovf(ova[1]), .done(dn[1]), .busy(bsy[1]));
  chunked_adder #(.WIDTH(16), .CHUNK(16)) u2 (.clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(rdy[2]),
    .x(x[15:0]), .y(y[15:0]), .ci(ci), .sub(sub), .o(o2), .co(coa[2]), .ovf(ova[2]), .done(dn[2]), .busy(bsy[2]));
  chunked_adder #(.WIDTH(32), .CHUNK(8)) u3 (.clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(rdy[3]),
    .x(x), .y(y), .ci(ci), .sub(sub), .o(o3), .co(coa[3]), .ovf(ova[3]), .done(dn[3]), .busy(bsy[3]));
  assign oa[0] = {16'h0, o0};
  assign oa[1] = {16'h0, o1};
  assign oa[2] = {16'h0, o2};
  assign oa[3] = o3;

  function automatic void ref_op(input int w, input logic [31:0] a, input logic [31:0] b, input bit c, input bit s,
                                 output logic [31:0] ro, output bit rco, output bit rovf);
    longint mask, ua, ub, sa, sb, u, sg;
    mask = (64'sd1 <<< w) - 1;
    ua = longint'(a) & mask;
    ub = longint'(b) & mask;
    sa = ua[w-1] ? ua - (64'sd1 <<< w) : ua;
    sb = ub[w-1] ? ub - (64'sd1 <<< w) : ub;
    if (s) begin
      u = ua - ub - longint'(c);
      rco = u >= 0;
      sg = sa - sb - longint'(c);
    end else begin
      u = ua + ub + longint'(c);
      rco = u > mask;
      sg = sa + sb + longint'(c);
    end
    ro = 32'(u & mask);
    rovf = sg < -(64'sd1 <<< (w - 1)) || sg > (64'sd1 <<< (w - 1)) - 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit c, input bit s, output int lat);
    x = {16'h0, a};
    y = {16'h0, b};
    ci = c;
    sub = s;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (dn[0]) begin
        lat = i;
        break;
      end
      checks++;
      if (rdy[0] !== 1'b0) begin
        failures++;
        $display("FAIL ready_during_run: got %b want 0 at cycle %0d", rdy[0], i);
      end
    end
  endtask

  task automatic check_res(input string nm, input logic [15:0] eo, input bit eco, input bit eovf, input int lat);
    checks++;
    if (lat !== 4) begin
      failures++;
      $display("FAIL %s latency: got %0d want 4", nm, lat);
    end
    checks++;
    if ({o0, coa[0], ova[0]} !== {eo, eco, eovf}) begin
      failures++;
      $display("FAIL %s result: got o=%h co=%b ovf=%b want o=%h co=%b ovf=%b", nm, o0, coa[0], ova[0], eo, eco, eovf);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({o0, coa[0], ova[0], dn[0], bsy[0], rdy[0]} !== 22'h0) begin
      failures++;
      $display("FAIL reset_state: got o=%h co=%b ovf=%b done=%b busy=%b ready=%b want all 0", o0, coa[0], ova[0], dn[0], bsy[0], rdy[0]);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (rdy[0] !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got %b want 1", rdy[0]);
    end
  endtask

  task automatic test_add();
    int lat;
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
    check_res("add_wrap", 16'h0000, 1'b1, 1'b0, lat);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
    check_res("add_ovf", 16'h8000, 1'b0, 1'b1, lat);
    run_op(16'h1234, 16'h1111, 1'b1, 1'b0, lat);
    check_res("add_ci", 16'h2346, 1'b0, 1'b0, lat);
  endtask

  task automatic test_sub();
    int lat;
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, lat);
    check_res("sub_neg", 16'hFFFE, 1'b0, 1'b0, lat);
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, lat);
    check_res("sub_ovf", 16'h7FFF, 1'b1, 1'b1, lat);
    run_op(16'h0010, 16'h0001, 1'b1, 1'b1, lat);
    check_res("sub_borrow", 16'h000E, 1'b1, 1'b0, lat);
  endtask

  task automatic test_back_to_back();
    int lat;
    x = 32'h0100;
    y = 32'h0200;
    ci = 1'b0;
    sub = 1'b0;
    start_valid = 1'b1;
    tick();
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (dn[0]) begin
        lat = i;
        break;
      end
    end
    check_res("b2b_first", 16'h0300, 1'b0, 1'b0, lat);
    checks++;
    if (rdy[0] !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ready_with_done: got %b want 1", rdy[0]);
    end
    x = 32'h1000;
    y = 32'h0034;
    ci = 1'b1;
    tick();
    start_valid = 1'b0;
    checks++;
    if ({dn[0], bsy[0], o0} !== {1'b0, 1'b1, 16'h0300}) begin
      failures++;
      $display("FAIL b2b_accept: got done=%b busy=%b o=%h want 0 1 0300", dn[0], bsy[0], o0);
    end
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (dn[0]) begin
        lat = i;
        break;
      end
      checks++;
      if (o0 !== 16'h0300) begin
        failures++;
        $display("FAIL b2b_hold: got o=%h want 0300", o0);
      end
    end
    check_res("b2b_second", 16'h1035, 1'b0, 1'b0, lat);
  endtask

  task automatic test_ignore_busy();
    int lat;
    x = 32'h0003;
    y = 32'h0004;
    ci = 1'b0;
    sub = 1'b0;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    tick();
    start_valid = 1'b1;
    x = 32'hAAAA;
    y = 32'h5555;
    tick();
    start_valid = 1'b0;
    lat = 0;
    for (int i = 3; i <= 20; i++) begin
      tick();
      if (dn[0]) begin
        lat = i;
        break;
      end
    end
    check_res("ignore_busy", 16'h0007, 1'b0, 1'b0, lat);
    tick();
    checks++;
    if ({bsy[0], dn[0]} !== 2'b00) begin
      failures++;
      $display("FAIL ignore_no_queue: got busy=%b done=%b want 0 0", bsy[0], dn[0]);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    x = 32'h1111;
    y = 32'h2222;
    ci = 1'b0;
    sub = 1'b0;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({o0, coa[0], ova[0], dn[0], bsy[0], rdy[0]} !== 22'h0) begin
      failures++;
      $display("FAIL reset_mid_state: got o=%h co=%b ovf=%b done=%b busy=%b ready=%b want all 0", o0, coa[0], ova[0], dn[0], bsy[0], rdy[0]);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (rdy[0] !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_ready: got %b want 1", rdy[0]);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if ({dn[0], o0} !== 17'h0) begin
        failures++;
        $display("FAIL reset_mid_no_done: got done=%b o=%h want 0 0000", dn[0], o0);
      end
    end
    run_op(16'h1111, 16'h2222, 1'b0, 1'b0, lat);
    check_res("reset_mid_next", 16'h3333, 1'b0, 1'b0, lat);
  endtask

  task automatic test_sweep();
    logic [3:0] seen;
    logic [31:0] eo;
    bit eco, eovf;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      x = $urandom;
      y = $urandom;
      ci = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      start_valid = 1'b1;
      tick();
      start_valid = 1'b0;
      seen = '0;
      for (int t = 1; t <= 40 && seen != 4'hF; t++) begin
        tick();
        for (int j = 0; j < 4; j++) begin
          if (dn[j] && !seen[j]) begin
            seen[j] = 1'b1;
            checks++;
            if (t != NN[j]) begin
              failures++;
              $display("FAIL sweep_latency dut%0d: got %0d want %0d", j, t, NN[j]);
            end
            ref_op(W[j], x, y, ci, sub, eo, eco, eovf);
            checks++;
            if ({oa[j], coa[j], ova[j]} !== {eo, eco, eovf}) begin
              failures++;
              $display("FAIL sweep_result dut%0d x=%h y=%h ci=%b sub=%b: got o=%h co=%b ovf=%b want o=%h co=%b ovf=%b",
                       j, x, y, ci, sub, oa[j], coa[j], ova[j], eo, eco, eovf);
            end
          end
        end
      end
      for (int j = 0; j < 4; j++) begin
        if (!seen[j]) begin
          checks++;
          failures++;
          $display("FAIL sweep_timeout dut%0d: got no done want done", j);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/chunked_adder.md
Name: chunked_adder

Overview:
Parametrised multi-cycle adder/subtractor, successor to the 16-bit ripple adder. Processes a WIDTH-bit operand pair CHUNK bits per clock, with a registered carry between chunks. Provides carry-in, subtract mode, carry-out and signed overflow, plus a valid/ready start handshake and a done pulse. Sits in the ALU where area matters more than single-cycle latency.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
CHUNK, 4, bits added per cycle; 1 <= CHUNK <= WIDTH. N = WIDTH/CHUNK cycles per operation.

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  synchronous reset, active-high
start_valid  input  1  request to start an operation
start_ready  output  1  block can accept a request (high only in IDLE)
x  input  WIDTH  operand A; sampled only on acceptance
y  input  WIDTH  operand B; sampled only on acceptance
ci  input  1  carry-in (add) / borrow-in (sub); sampled on acceptance
sub  input  1  0: o = x + y + ci; 1: o = x - y - ci; sampled on acceptance
o  output  WIDTH  result, registered, held until next completion
co  output  1  raw carry out of MSB (sub: 1 = no borrow)
ovf  output  1  two's-complement overflow
done  output  1  one-cycle pulse, results updated
busy  output  1  high while in RUN

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, chunk index=0, internal carry=0, o=0, co=0, ovf=0, done=0. Overrides everything, including mid-operation. An aborted operation never produces done and never updates o/co/ovf.
- States: IDLE, RUN. start_ready = (state==IDLE) and !rst. busy = (state==RUN).
- Acceptance: start_valid && start_ready at edge E0.
  - Latch x into opA.
  - Latch opB = sub ? ~y : y.
  - Latch carry = sub ? ~ci : ci. Subtract is therefore x + ~y + ~ci = x - y - ci mod 2^WIDTH.
  - Index k=0; go to RUN.
- RUN, cycle k (0..N-1):
  - Compute opA[k*CHUNK +: CHUNK] + opB[same] + carry.
  - Write the low CHUNK bits into the shadow result; carry <= chunk carry-out; k <= k+1.
- On the last chunk (k=N-1), at edge E_N:
  - o <= full shadow result including the final chunk; co <= final carry.
  - ovf <= carry into bit WIDTH-1 XOR carry out of bit WIDTH-1. Both are computed inside the last chunk.
  - done <= 1; state <= IDLE; k <= 0.
- Latency: accept at E0 → done high for exactly one cycle after E_N, i.e. N cycles after acceptance.
  - o/co/ovf change only at E_N and are stable from then until the next completion.
  - Intermediate chunks never appear on o.
- done is high in the same cycle start_ready returns high. A start_valid held high is accepted at the edge ending the done cycle, giving back-to-back throughput of one operation per N+1 cycles.
- start_valid while busy is ignored: no queuing, and inputs are not sampled. Input changes during RUN have no effect.
- CHUNK==WIDTH (N=1): one RUN cycle; done asserts one cycle after acceptance.
- CHUNK==1: bit-serial, N=WIDTH cycles.
- Index counter width = max(1, clog2(N)). No wrap beyond N-1.
- Result is identical to a WIDTH-bit ripple-carry add of the same effective operands for all inputs.

Test Plan:
1. WIDTH=16, CHUNK=4, add: x=0xFFFF, y=0x0001, ci=0 → done exactly 4 cycles after acceptance; o=0x0000, co=1, ovf=0; start_ready low for 4 cycles.
2. Add: x=0x7FFF, y=0x0001, ci=0 → o=0x8000, co=0, ovf=1. Add with ci=1: x=0x1234, y=0x1111 → o=0x2346, co=0, ovf=0.
3. Sub: x=0x0005, y=0x0007, ci=0 → o=0xFFFE, co=0, ovf=0. Sub: x=0x8000, y=0x0001, ci=0 → o=0x7FFF, co=1, ovf=1. Sub with borrow: x=0x0010, y=0x0001, ci=1 → o=0x000E, co=1.
4. Handshake:
   - start_valid held high with two operand sets → second accepted at the edge ending the first done cycle; o holds the first result until the second done.
   - Pulse start_valid and change x during RUN → ignored; result uses the latched x.
5. Reset mid-operation: rst=1 at RUN cycle 2 → no done pulse; o=0, co=0, ovf=0; start_ready=1 the cycle after rst deasserts; a new operation then completes correctly.
6. Parameter sweep: CHUNK ∈ {1, 4, 16} at WIDTH=16, plus WIDTH=32/CHUNK=8; 1000 random x/y/ci/sub each → o/co/ovf match the reference model; done latency = WIDTH/CHUNK.
